// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: skid-stage state encoding and
// the packed EX/MEM bundle carried as the stage payload.
package pipe_pkg;

    localparam int unsigned EXMEM_W = 114;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd_addr;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  mem_size;
        logic [1:0]  wb_sel;
        logic        mem_unsigned;
        logic        trap;
        logic        is_branch;
    } exmem_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q != '1)) begin
            q_d = q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with flush and a back-pressure counter.
// in_ready is decoded from state only, so out_ready never reaches the producer.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = EXMEM_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept, pop;

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        out_data  = out_valid ? main_q : '0;
        occupancy = state_q;
        accept    = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (out_valid & ~out_ready),
        .q   (stall_cnt)
    );

endmodule
